// File: rtl/apu_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : apu_frame_sequencer_pkg
// Brief  : Shared constants and helpers for the 2A03 frame sequencer:
//          default step counts, envelope control field positions and
//          frame-counter mode encodings.
// Rev    : 1.0  initial release
// ============================================================================
package apu_frame_sequencer_pkg;

    localparam int unsigned c_cnt_w     = 15;

    localparam int unsigned c_step1_def = 3728;
    localparam int unsigned c_step2_def = 7456;
    localparam int unsigned c_step3_def = 11185;
    localparam int unsigned c_step4_def = 14914;
    localparam int unsigned c_step5_def = 18640;

    // Envelope control byte layout: [5] loop, [4] constant, [3:0] vol/period
    localparam int unsigned c_env_loop  = 5;
    localparam int unsigned c_env_const = 4;

    localparam logic c_mode_4step = 1'b0;
    localparam logic c_mode_5step = 1'b1;

    // Envelope output: constant volume field or the decay level
    function automatic logic [3:0] env_level(input logic [5:0] ctrl,
                                             input logic [3:0] decay);
        return ctrl[c_env_const] ? ctrl[3:0] : decay;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : apu_frame_sequencer_if
// Brief  : Register-file side bundle for the frame sequencer. The master
//          modport is the APU register file, the slave modport is the
//          sequencer itself.
// Rev    : 1.0  initial release
// ============================================================================
interface apu_frame_sequencer_if;
    logic       apu_tick_i;
    logic       frame_wr_i;
    logic [7:0] frame_data_i;
    logic       irq_ack_i;
    logic [5:0] env_p1_i;
    logic [5:0] env_p2_i;
    logic [5:0] env_nz_i;
    logic [2:0] env_start_i;
    logic       quarter_o;
    logic       half_o;
    logic       frame_irq_o;
    logic [3:0] vol_p1_o;
    logic [3:0] vol_p2_o;
    logic [3:0] vol_nz_o;

    modport master (
        output apu_tick_i, frame_wr_i, frame_data_i, irq_ack_i,
               env_p1_i, env_p2_i, env_nz_i, env_start_i,
        input  quarter_o, half_o, frame_irq_o, vol_p1_o, vol_p2_o, vol_nz_o
    );

    modport slave (
        input  apu_tick_i, frame_wr_i, frame_data_i, irq_ack_i,
               env_p1_i, env_p2_i, env_nz_i, env_start_i,
        output quarter_o, half_o, frame_irq_o, vol_p1_o, vol_p2_o, vol_nz_o
    );
endinterface
`default_nettype wire

// File: rtl/apu_frame_sequencer_envelope.sv
`default_nettype none
// ============================================================================
// Module : apu_envelope
// Brief  : One envelope unit (start flag, divider, decay level). Clocked by
//          the quarter-frame strobe; volume is combinational from the regs.
// Rev    : 1.0  initial release
// ============================================================================
module apu_envelope
    import apu_frame_sequencer_pkg::*;
(
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    input  wire logic       quarter,
    input  wire logic       start,
    input  wire logic [5:0] ctrl,
    output logic      [3:0] vol
);

    logic       r_start;
    logic [3:0] r_decay;
    logic [3:0] r_div;
    logic       w_start_seen;

    // A start pulse arriving with the quarter is honoured by that quarter
    assign w_start_seen = r_start | start;

    // Start flag, divider and decay level update on each quarter-frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_start <= 1'b0;
            r_decay <= 4'd0;
            r_div   <= 4'd0;
        end else if (quarter) begin
            if (w_start_seen) begin
                r_start <= 1'b0;
                r_decay <= 4'd15;
                r_div   <= ctrl[3:0];
            end else if (r_div == 4'd0) begin
                r_div <= ctrl[3:0];
                if (r_decay != 4'd0) begin
                    r_decay <= r_decay - 4'd1;
                end else if (ctrl[c_env_loop]) begin
                    r_decay <= 4'd15;
                end
            end else begin
                r_div <= r_div - 4'd1;
            end
        end else if (start) begin
            r_start <= 1'b1;
        end
    end

    assign vol = env_level(ctrl, r_decay);

endmodule
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module : apu_frame_sequencer
// Brief  : 2A03 frame counter ($4017) with quarter/half-frame strobes, frame
//          IRQ and three envelope units (pulse1, pulse2, noise).
//          Optional feature macro: APU_FRAME_IRQ_EN (frame IRQ, inhibit and
//          acknowledge logic; when undefined frame_irq_o is tied low).
// Rev    : 1.0  initial release
// ============================================================================
module apu_frame_sequencer
    import apu_frame_sequencer_pkg::*;
#(
    parameter int unsigned STEP1 = c_step1_def,
    parameter int unsigned STEP2 = c_step2_def,
    parameter int unsigned STEP3 = c_step3_def,
    parameter int unsigned STEP4 = c_step4_def,
    parameter int unsigned STEP5 = c_step5_def
)(
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    apu_frame_sequencer_if.slave bus
);

    localparam logic [c_cnt_w-1:0] c_s1 = c_cnt_w'(STEP1);
    localparam logic [c_cnt_w-1:0] c_s2 = c_cnt_w'(STEP2);
    localparam logic [c_cnt_w-1:0] c_s3 = c_cnt_w'(STEP3);
    localparam logic [c_cnt_w-1:0] c_s4 = c_cnt_w'(STEP4);
    localparam logic [c_cnt_w-1:0] c_s5 = c_cnt_w'(STEP5);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mode;
    logic               r_quarter;
    logic               r_half;

    logic [c_cnt_w-1:0] w_last;
    logic               w_tick;
    logic               w_at_last;
    logic               w_hit_q;
    logic               w_hit_h;
    logic               w_wr_5step;
    logic               w_unused;

    // A $4017 write in the same clk swallows the tick
    assign w_tick     = bus.apu_tick_i & ~bus.frame_wr_i;
    assign w_last     = (r_mode == c_mode_5step) ? c_s5 : c_s4;
    assign w_at_last  = (r_cnt == w_last);
    // STEP4 only decodes as the last step, so it is silent in 5-step mode
    assign w_hit_q    = (r_cnt == c_s1) | (r_cnt == c_s2) | (r_cnt == c_s3) | w_at_last;
    assign w_hit_h    = (r_cnt == c_s2) | w_at_last;
    assign w_wr_5step = bus.frame_wr_i & (bus.frame_data_i[7] == c_mode_5step);

    // Frame counter and mode latch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_mode <= c_mode_4step;
        end else if (bus.frame_wr_i) begin
            r_cnt  <= '0;
            r_mode <= bus.frame_data_i[7];
        end else if (w_tick) begin
            r_cnt  <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Registered one-clk strobes from the step decode or a 5-step write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_quarter <= w_wr_5step | (w_tick & w_hit_q);
            r_half    <= w_wr_5step | (w_tick & w_hit_h);
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic r_inhibit;
    logic r_irq;
    logic w_irq_set;

    assign w_irq_set = w_tick & w_at_last & (r_mode == c_mode_4step) & ~r_inhibit;

    // Frame IRQ flag: set has priority over acknowledge and inhibit clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (bus.frame_wr_i) begin
                r_inhibit <= bus.frame_data_i[6];
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (bus.irq_ack_i | (bus.frame_wr_i & bus.frame_data_i[6])) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign bus.frame_irq_o = r_irq;
    assign w_unused        = ^bus.frame_data_i[5:0];
`else
    assign bus.frame_irq_o = 1'b0;
    assign w_unused        = ^{bus.irq_ack_i, bus.frame_data_i[6:0]};
`endif

    assign bus.quarter_o = r_quarter;
    assign bus.half_o    = r_half;

    apu_envelope u_env_p1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .quarter (r_quarter),
        .start   (bus.env_start_i[0]),
        .ctrl    (bus.env_p1_i),
        .vol     (bus.vol_p1_o)
    );

    apu_envelope u_env_p2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .quarter (r_quarter),
        .start   (bus.env_start_i[1]),
        .ctrl    (bus.env_p2_i),
        .vol     (bus.vol_p2_o)
    );

    apu_envelope u_env_nz (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .quarter (r_quarter),
        .start   (bus.env_start_i[2]),
        .ctrl    (bus.env_nz_i),
        .vol     (bus.vol_nz_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_apu_frame_sequencer
// Brief  : Self-checking bench for apu_frame_sequencer: frame-counter
//          segments from a table, plus directed IRQ, envelope and reset
//          sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_apu_frame_sequencer;

`ifdef APU_FRAME_IRQ_EN
    localparam logic c_irq_en = 1'b1;
`else
    localparam logic c_irq_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apu_frame_sequencer_if bus();

    apu_frame_sequencer u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;
    int   q_log[$];
    int   h_log[$];
    logic prev_q = 1'b0;
    logic prev_h = 1'b0;

    typedef struct {
        string      name;
        logic       do_wr;
        logic [7:0] wdata;
        logic       wtick;
        int         n;
        int         nq;
        int         q[6];
        int         nh;
        int         h[6];
        logic       exp_irq;
    } seg_t;

    seg_t segs[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Sample outputs at the falling edge, then drive the next cycle's inputs
    task automatic cyc(input logic tick, input logic wr, input logic [7:0] data,
                       input logic ack, input logic [2:0] start);
        @(negedge clk);
        if (bus.quarter_o === 1'b1) begin
            q_log.push_back(ticks);
            chk("quarter_width", {31'd0, prev_q}, 32'd0);
        end
        if (bus.half_o === 1'b1) begin
            h_log.push_back(ticks);
            chk("half_width", {31'd0, prev_h}, 32'd0);
        end
        prev_q = bus.quarter_o;
        prev_h = bus.half_o;
        if (wr) ticks = 0;
        else if (tick) ticks++;
        bus.apu_tick_i   = tick;
        bus.frame_wr_i   = wr;
        bus.frame_data_i = data;
        bus.irq_ack_i    = ack;
        bus.env_start_i  = start;
    endtask

    // One quarter-frame via a 5-step write, with time for the envelope to update
    task automatic qp();
        cyc(1'b0, 1'b1, 8'h80, 1'b0, 3'b000);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b000);
    endtask

    task automatic irq_seq();
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 3'b000);
        idle();
        chk("irq_ack_clr", {31'd0, bus.frame_irq_o}, 32'd0);
        repeat (14914) cyc(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 3'b000);
        idle();
        chk("irq_set_wins", {31'd0, bus.frame_irq_o}, {31'd0, c_irq_en});
        cyc(1'b0, 1'b1, 8'h40, 1'b0, 3'b000);
        idle();
        chk("irq_inhibit_clr", {31'd0, bus.frame_irq_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        segs[0] = '{"4s_step1", 1'b0, 8'h00, 1'b0, 3729,
                    1, '{3729, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0}, 1'b0};
        segs[1] = '{"4s_rest", 1'b0, 8'h00, 1'b0, 11186,
                    3, '{7457, 11186, 14915, 0, 0, 0}, 2, '{7457, 14915, 0, 0, 0, 0}, c_irq_en};
        segs[2] = '{"5s_frame", 1'b1, 8'h80, 1'b1, 18641,
                    5, '{0, 3729, 7457, 11186, 18641, 0}, 3, '{0, 7457, 18641, 0, 0, 0}, 1'b0};
        segs[3] = '{"4s_wr00", 1'b1, 8'h00, 1'b0, 3729,
                    1, '{3729, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0}, 1'b0};

        bus.apu_tick_i   = 1'b0;
        bus.frame_wr_i   = 1'b0;
        bus.frame_data_i = 8'h00;
        bus.irq_ack_i    = 1'b0;
        bus.env_p1_i     = 6'h00;
        bus.env_p2_i     = 6'h00;
        bus.env_nz_i     = 6'h00;
        bus.env_start_i  = 3'b000;

        repeat (3) @(negedge clk);
        chk("rst_quarter", {31'd0, bus.quarter_o},   32'd0);
        chk("rst_half",    {31'd0, bus.half_o},      32'd0);
        chk("rst_irq",     {31'd0, bus.frame_irq_o}, 32'd0);
        chk("rst_vol_p1",  {28'd0, bus.vol_p1_o},    32'd0);
        chk("rst_vol_nz",  {28'd0, bus.vol_nz_o},    32'd0);
        rst   = 1'b0;
        ticks = 0;

        for (int i = 0; i < 4; i++) begin
            q_log.delete();
            h_log.delete();
            if (segs[i].do_wr) cyc(segs[i].wtick, 1'b1, segs[i].wdata, 1'b0, 3'b000);
            repeat (segs[i].n) cyc(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);
            idle();
            chk({segs[i].name, "_nq"}, q_log.size(), segs[i].nq);
            for (int j = 0; j < segs[i].nq; j++)
                if (j < q_log.size()) chk({segs[i].name, "_qpos"}, q_log[j], segs[i].q[j]);
            chk({segs[i].name, "_nh"}, h_log.size(), segs[i].nh);
            for (int j = 0; j < segs[i].nh; j++)
                if (j < h_log.size()) chk({segs[i].name, "_hpos"}, h_log[j], segs[i].h[j]);
            chk({segs[i].name, "_irq"}, {31'd0, bus.frame_irq_o}, {31'd0, segs[i].exp_irq});
            if (i == 1) irq_seq();
        end

        // Envelopes: p1 decaying with period 3, p2 constant 7, noise period 15
        bus.env_p1_i = 6'h03;
        bus.env_p2_i = 6'h17;
        bus.env_nz_i = 6'h0F;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b111);
        qp();
        chk("env_p1_load", {28'd0, bus.vol_p1_o}, 32'd15);
        chk("env_nz_load", {28'd0, bus.vol_nz_o}, 32'd15);
        chk("env_p2_const", {28'd0, bus.vol_p2_o}, 32'd7);
        repeat (3) qp();
        chk("env_p1_hold3", {28'd0, bus.vol_p1_o}, 32'd15);
        qp();
        chk("env_p1_dec", {28'd0, bus.vol_p1_o}, 32'd14);
        for (int k = 1; k <= 14; k++) begin
            repeat (4) qp();
            chk("env_p1_dec", {28'd0, bus.vol_p1_o}, 32'(14 - k));
        end
        repeat (8) qp();
        chk("env_p1_hold0", {28'd0, bus.vol_p1_o}, 32'd0);
        bus.env_p1_i = 6'h23;
        repeat (3) qp();
        chk("env_p1_loop_pre", {28'd0, bus.vol_p1_o}, 32'd0);
        qp();
        chk("env_p1_loop_wrap", {28'd0, bus.vol_p1_o}, 32'd15);
        chk("env_p2_const_end", {28'd0, bus.vol_p2_o}, 32'd7);

        // Start pulse coinciding with the quarter strobe
        cyc(1'b0, 1'b1, 8'h80, 1'b0, 3'b000);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b001);
        idle();
        chk("env_ss_load", {28'd0, bus.vol_p1_o}, 32'd15);
        repeat (3) qp();
        chk("env_ss_hold3", {28'd0, bus.vol_p1_o}, 32'd15);
        qp();
        chk("env_ss_dec", {28'd0, bus.vol_p1_o}, 32'd14);

        // Asynchronous reset mid-frame at cnt = 5000
        bus.env_p2_i = 6'h00;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 3'b001);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 3'b000);
        repeat (5000) cyc(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);
        idle();
        chk("rst_pre_vol_p1", {28'd0, bus.vol_p1_o}, 32'd15);
        #2 rst = 1'b1;
        #1;
        chk("arst_quarter", {31'd0, bus.quarter_o},   32'd0);
        chk("arst_half",    {31'd0, bus.half_o},      32'd0);
        chk("arst_irq",     {31'd0, bus.frame_irq_o}, 32'd0);
        chk("arst_vol_p1",  {28'd0, bus.vol_p1_o},    32'd0);
        chk("arst_vol_p2",  {28'd0, bus.vol_p2_o},    32'd0);
        chk("arst_vol_nz",  {28'd0, bus.vol_nz_o},    32'd0);
        ticks = 0;
        repeat (2) idle();
        rst = 1'b0;
        q_log.delete();
        h_log.delete();
        repeat (3729) cyc(1'b1, 1'b0, 8'h00, 1'b0, 3'b000);
        idle();
        chk("post_rst_nq", q_log.size(), 1);
        if (q_log.size() > 0) chk("post_rst_qpos", q_log[0], 3729);
        chk("post_rst_nh", h_log.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
